// File: rtl/watchdog_mc.sv
// Multi-channel watchdog: shared prescaler, per-channel timeout, pre-expiry warning,
// early-kick window detection and sticky expiry with acknowledge.
//
// state   | meaning
// IDLE    | channel disabled, count held at 0
// RUN     | counting prescaled ticks toward timeout
// WARN    | counting, count has reached warn_at
// EXPIRED | timeout reached or early kick; count frozen until ack
module watchdog_mc #(
  parameter int CHANNELS = 2,
  parameter int CNT_W    = 16,
  parameter int PRESC_W  = 8
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [PRESC_W-1:0]        prescale,
  input  logic [CHANNELS-1:0]       ch_en,
  input  logic [CHANNELS-1:0]       ch_kick,
  input  logic [CHANNELS-1:0]       ch_ack,
  input  logic [CHANNELS*CNT_W-1:0] ch_timeout,
  input  logic [CHANNELS*CNT_W-1:0] ch_warn_at,
  input  logic [CHANNELS*CNT_W-1:0] ch_win_min,
  output logic [CHANNELS*CNT_W-1:0] ch_count,
  output logic [CHANNELS-1:0]       ch_warn,
  output logic [CHANNELS-1:0]       ch_expired,
  output logic [CHANNELS-1:0]       ch_early,
  output logic                      halt_req
);

  typedef enum logic [1:0] {IDLE, RUN, WARN, EXPIRED} state_t;

  logic [PRESC_W-1:0] pcnt;
  logic               tick;

  // >= rather than == so a prescale lowered below pcnt ticks immediately
  assign tick = (pcnt >= prescale);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) pcnt <= '0;
    else if (tick) pcnt <= '0;
    else pcnt <= pcnt + 1'b1;
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    state_t           state;
    logic [CNT_W-1:0] count;
    logic             warn_r;
    logic             exp_r;
    logic             early_r;
    logic [CNT_W-1:0] timeout;
    logic [CNT_W-1:0] warn_at;
    logic [CNT_W-1:0] win_min;
    logic [CNT_W:0]   nxt;

    assign timeout = ch_timeout[gi*CNT_W +: CNT_W];
    assign warn_at = ch_warn_at[gi*CNT_W +: CNT_W];
    assign win_min = ch_win_min[gi*CNT_W +: CNT_W];
    // one extra bit so count+1 never wraps at the top of the range
    assign nxt     = {1'b0, count} + 1'b1;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        state   <= IDLE;
        count   <= '0;
        warn_r  <= 1'b0;
        exp_r   <= 1'b0;
        early_r <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (ch_en[gi]) begin
              state <= RUN;
              count <= '0;
            end
          end
          RUN, WARN: begin
            if (!ch_en[gi]) begin
              state  <= IDLE;
              count  <= '0;
              warn_r <= 1'b0;
            end else if (ch_kick[gi]) begin
              warn_r <= 1'b0;
              if (win_min != '0 && count < win_min) begin
                state   <= EXPIRED;
                exp_r   <= 1'b1;
                early_r <= 1'b1;
              end else begin
                state <= RUN;
                count <= '0;
              end
            end else if (tick) begin
              if (nxt >= {1'b0, timeout}) begin
                state  <= EXPIRED;
                count  <= timeout;
                exp_r  <= 1'b1;
                warn_r <= 1'b0;
              end else begin
                count <= nxt[CNT_W-1:0];
                if (warn_at != '0 && nxt >= {1'b0, warn_at}) begin
                  state  <= WARN;
                  warn_r <= 1'b1;
                end else begin
                  state  <= RUN;
                  warn_r <= 1'b0;
                end
              end
            end
          end
          EXPIRED: begin
            if (ch_ack[gi]) begin
              state   <= IDLE;
              count   <= '0;
              exp_r   <= 1'b0;
              early_r <= 1'b0;
            end
          end
          default: begin
            state  <= IDLE;
            count  <= '0;
            warn_r <= 1'b0;
            exp_r  <= 1'b0;
          end
        endcase
      end
    end

    assign ch_count[gi*CNT_W +: CNT_W] = count;
    assign ch_warn[gi]    = warn_r;
    assign ch_expired[gi] = exp_r;
    assign ch_early[gi]   = early_r;
  end

  assign halt_req = |ch_expired;

endmodule

// File: tb/tb_watchdog_mc.sv
// Bench for watchdog_mc: reference-model comparison every cycle, a vector table
// for the single-channel walk-through, hand sequences for corners, then random traffic.
module tb_watchdog_mc;
  localparam int CH = 2;
  localparam int CW = 16;
  localparam int PW = 8;

  logic             clk = 1'b0;
  logic             rstn;
  logic [PW-1:0]    prescale;
  logic [CH-1:0]    ch_en, ch_kick, ch_ack;
  logic [CH*CW-1:0] ch_timeout, ch_warn_at, ch_win_min;
  logic [CH*CW-1:0] ch_count;
  logic [CH-1:0]    ch_warn, ch_expired, ch_early;
  logic             halt_req;

  watchdog_mc #(.CHANNELS(CH), .CNT_W(CW), .PRESC_W(PW)) dut (
    .clk(clk), .rstn(rstn), .prescale(prescale),
    .ch_en(ch_en), .ch_kick(ch_kick), .ch_ack(ch_ack),
    .ch_timeout(ch_timeout), .ch_warn_at(ch_warn_at), .ch_win_min(ch_win_min),
    .ch_count(ch_count), .ch_warn(ch_warn), .ch_expired(ch_expired),
    .ch_early(ch_early), .halt_req(halt_req)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model: mode 0 = off, 1 = counting, 2 = expired
  int m_pcnt;
  int m_cnt  [CH];
  int m_mode [CH];
  bit m_warn [CH];
  bit m_early[CH];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pcnt = 0;
    for (int c = 0; c < CH; c++) begin
      m_cnt[c] = 0; m_mode[c] = 0; m_warn[c] = 0; m_early[c] = 0;
    end
  endtask

  task automatic model_edge();
    bit tick;
    int to, wa, wm, n;
    tick = (m_pcnt >= int'(prescale));
    m_pcnt = tick ? 0 : m_pcnt + 1;
    for (int c = 0; c < CH; c++) begin
      to = int'(ch_timeout[c*CW +: CW]);
      wa = int'(ch_warn_at[c*CW +: CW]);
      wm = int'(ch_win_min[c*CW +: CW]);
      if (m_mode[c] == 0) begin
        if (ch_en[c]) begin m_mode[c] = 1; m_cnt[c] = 0; end
      end else if (m_mode[c] == 2) begin
        if (ch_ack[c]) begin m_mode[c] = 0; m_cnt[c] = 0; m_early[c] = 0; end
      end else if (!ch_en[c]) begin
        m_mode[c] = 0; m_cnt[c] = 0; m_warn[c] = 0;
      end else if (ch_kick[c]) begin
        m_warn[c] = 0;
        if (wm != 0 && m_cnt[c] < wm) begin m_mode[c] = 2; m_early[c] = 1; end
        else m_cnt[c] = 0;
      end else if (tick) begin
        n = m_cnt[c] + 1;
        if (n >= to) begin m_mode[c] = 2; m_cnt[c] = to; m_warn[c] = 0; end
        else begin m_cnt[c] = n; m_warn[c] = (wa != 0 && n >= wa); end
      end
    end
  endtask

  task automatic check_model();
    bit any;
    any = 0;
    for (int c = 0; c < CH; c++) begin
      check($sformatf("model_count%0d", c), int'(ch_count[c*CW +: CW]), m_cnt[c]);
      check($sformatf("model_warn%0d", c), int'(ch_warn[c]), int'(m_warn[c]));
      check($sformatf("model_expired%0d", c), int'(ch_expired[c]), int'(m_mode[c] == 2));
      check($sformatf("model_early%0d", c), int'(ch_early[c]), int'(m_early[c]));
      if (m_mode[c] == 2) any = 1;
    end
    check("model_halt", int'(halt_req), int'(any));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic set_cfg(input int c, input int to, input int wa, input int wm);
    ch_timeout[c*CW +: CW] = CW'(to);
    ch_warn_at[c*CW +: CW] = CW'(wa);
    ch_win_min[c*CW +: CW] = CW'(wm);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    prescale = '0; ch_en = '0; ch_kick = '0; ch_ack = '0;
    ch_timeout = '0; ch_warn_at = '0; ch_win_min = '0;
    model_reset();
    @(negedge clk);
    check_model();
    rstn = 1'b1;
  endtask

  typedef struct {
    logic en, kick, ack;
    int   win;
    int   cnt;
    logic warn, expd, early, halt;
  } vec_t;

  vec_t vecs[26];

  initial begin
    int   last_chg, cur, prev;
    bit   seen;

    // CH0, prescale 0, timeout 10, warn_at 7
    vecs[0] = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
    for (int i = 1; i <= 10; i++)
      vecs[i] = '{1, 0, 0, 0, i, (i >= 7 && i < 10), (i == 10), 0, (i == 10)};
    vecs[11] = '{1, 1, 0, 0, 10, 0, 1, 0, 1};
    vecs[12] = '{1, 0, 1, 0, 0, 0, 0, 0, 0};
    vecs[13] = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
    for (int i = 14; i <= 18; i++)
      vecs[i] = '{1, 0, 0, 3, i - 13, 0, 0, 0, 0};
    vecs[19] = '{1, 1, 0, 3, 0, 0, 0, 0, 0};
    vecs[20] = '{1, 0, 0, 3, 1, 0, 0, 0, 0};
    vecs[21] = '{1, 0, 0, 3, 2, 0, 0, 0, 0};
    vecs[22] = '{1, 1, 0, 3, 2, 0, 1, 1, 1};
    vecs[23] = '{0, 0, 0, 3, 2, 0, 1, 1, 1};
    vecs[24] = '{0, 0, 1, 3, 0, 0, 0, 0, 0};
    vecs[25] = '{0, 1, 1, 3, 0, 0, 0, 0, 0};

    do_reset();
    set_cfg(0, 10, 7, 0);
    set_cfg(1, 100, 0, 0);
    for (int i = 0; i < 26; i++) begin
      ch_en[0] = vecs[i].en; ch_kick[0] = vecs[i].kick; ch_ack[0] = vecs[i].ack;
      ch_win_min[0 +: CW] = CW'(vecs[i].win);
      step();
      check($sformatf("vec%0d_count", i), int'(ch_count[0 +: CW]), vecs[i].cnt);
      check($sformatf("vec%0d_warn", i), int'(ch_warn[0]), int'(vecs[i].warn));
      check($sformatf("vec%0d_expired", i), int'(ch_expired[0]), int'(vecs[i].expd));
      check($sformatf("vec%0d_early", i), int'(ch_early[0]), int'(vecs[i].early));
      check($sformatf("vec%0d_halt", i), int'(halt_req), int'(vecs[i].halt));
    end
    ch_kick = '0; ch_ack = '0;

    // kick coinciding with the tick that would expire
    set_cfg(0, 5, 0, 0);
    ch_en[0] = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("kick_tick_pre", int'(ch_count[0 +: CW]), 4);
    ch_kick[0] = 1'b1;
    step();
    ch_kick[0] = 1'b0;
    check("kick_tick_count", int'(ch_count[0 +: CW]), 0);
    check("kick_tick_expired", int'(ch_expired[0]), 0);
    step();
    check("kick_tick_resume", int'(ch_count[0 +: CW]), 1);

    // disable while warning
    set_cfg(0, 20, 3, 0);
    ch_en[0] = 1'b0; step();
    ch_en[0] = 1'b1; step();
    for (int i = 0; i < 3; i++) step();
    check("warn_on", int'(ch_warn[0]), 1);
    ch_en[0] = 1'b0; step();
    check("dis_warn", int'(ch_warn[0]), 0);
    check("dis_count", int'(ch_count[0 +: CW]), 0);
    ch_kick[0] = 1'b1; ch_ack[0] = 1'b1; step();
    ch_kick[0] = 1'b0; ch_ack[0] = 1'b0; step();
    check("idle_ignore_count", int'(ch_count[0 +: CW]), 0);
    check("idle_ignore_expired", int'(ch_expired[0]), 0);

    // prescaled counting
    do_reset();
    prescale = 8'd3;
    set_cfg(0, 5, 0, 0);
    ch_en[0] = 1'b1;
    last_chg = -1; prev = 0; seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      step();
      cur = int'(ch_count[0 +: CW]);
      if (cur != prev) begin
        if (last_chg >= 0) check("presc_gap", k - last_chg, 4);
        last_chg = k;
        prev = cur;
      end
      if (ch_expired[0]) seen = 1;
    end
    check("presc_expired_seen", int'(seen), 1);
    check("presc_final_count", int'(ch_count[0 +: CW]), 5);

    // channel independence, then asynchronous reset mid-run
    do_reset();
    set_cfg(0, 4, 0, 0);
    set_cfg(1, 1000, 0, 0);
    ch_en = 2'b11;
    for (int i = 0; i < 6; i++) step();
    check("indep_ch0_expired", int'(ch_expired[0]), 1);
    check("indep_ch1_count", int'(ch_count[CW +: CW]), 5);
    check("indep_ch1_expired", int'(ch_expired[1]), 0);
    check("indep_halt", int'(halt_req), 1);
    #2;
    rstn = 1'b0;
    #1;
    check("arst_count", int'(ch_count), 0);
    check("arst_expired", int'(ch_expired), 0);
    check("arst_warn", int'(ch_warn), 0);
    check("arst_early", int'(ch_early), 0);
    check("arst_halt", int'(halt_req), 0);

    // random traffic against the model
    do_reset();
    for (int c = 0; c < CH; c++) set_cfg(c, $urandom_range(12), $urandom_range(12), $urandom_range(6));
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(63) == 0) prescale = PW'($urandom_range(3));
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(31) == 0)
          set_cfg(c, $urandom_range(12), $urandom_range(12), $urandom_range(6));
        if ($urandom_range(31) == 0) ch_en[c] = ~ch_en[c];
        else if ($urandom_range(7) == 0) ch_en[c] = 1'b1;
        ch_kick[c] = ($urandom_range(5) == 0);
        ch_ack[c]  = ($urandom_range(3) == 0);
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
